// File: rtl/codec_init_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : codec_init_pkg
//  Description : Shared types and the default SSM2603 init table for
//                codec_init_seq.
//                - codec_entry_t : {addr[6:0], data[8:0], delay_before, verify}
//                - codec_state_e : sequencer state encoding
//                - default_entry : table lookup by entry index
//  Revision    : 1.0 - initial release
// ============================================================================
package codec_init_pkg;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
        logic       delay_before;
        logic       verify;
    } codec_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ISSUE    = 4'd1,
        ST_WAIT_HI  = 4'd2,
        ST_WAIT_LO  = 4'd3,
        ST_CHECK    = 4'd4,
        ST_DELAY    = 4'd5,
        ST_RB_ISSUE = 4'd6,
        ST_RB_WAIT  = 4'd7,
        ST_DONE     = 4'd8,
        ST_ERROR    = 4'd9
    } codec_state_e;

    localparam int C_TABLE_LEN = 10;

    // R15 (reset) and the two R6 power writes are not read back: the reset
    // register is write-only in effect, and R6 changes are transient.
    function automatic codec_entry_t default_entry(input logic [3:0] idx);
        codec_entry_t e;
        e = '0;
        case (idx)
            4'd0:    e = '{addr: 7'h0F, data: 9'h000, delay_before: 1'b0, verify: 1'b0};
            4'd1:    e = '{addr: 7'h06, data: 9'h010, delay_before: 1'b0, verify: 1'b0};
            4'd2:    e = '{addr: 7'h00, data: 9'h017, delay_before: 1'b0, verify: 1'b1};
            4'd3:    e = '{addr: 7'h01, data: 9'h017, delay_before: 1'b0, verify: 1'b1};
            4'd4:    e = '{addr: 7'h04, data: 9'h012, delay_before: 1'b0, verify: 1'b1};
            4'd5:    e = '{addr: 7'h05, data: 9'h000, delay_before: 1'b0, verify: 1'b1};
            4'd6:    e = '{addr: 7'h07, data: 9'h00A, delay_before: 1'b0, verify: 1'b1};
            4'd7:    e = '{addr: 7'h08, data: 9'h000, delay_before: 1'b0, verify: 1'b1};
            4'd8:    e = '{addr: 7'h09, data: 9'h001, delay_before: 1'b1, verify: 1'b0};
            4'd9:    e = '{addr: 7'h06, data: 9'h000, delay_before: 1'b0, verify: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/codec_init_timer.sv
`default_nettype none
// ============================================================================
//  Module      : codec_init_timer
//  Description : Down-counter shared by the busy-rise timeout and the
//                activate delay. Load wins over enable; the count stops at 0.
//  Ports       : clk, reset_n      - clock, async active-low reset
//                i_load/i_load_value - load the count
//                i_enable          - decrement while non-zero
//                o_expired         - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module codec_init_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/codec_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : codec_init_seq
//  Description : Walks the codec init table, issuing one write request per
//                entry to an I2C sequencer, with retry on missed ACK or
//                busy-rise timeout and an optional pre-entry delay.
//                Optional feature macro: CODEC_INIT_READBACK_EN adds a
//                readback compare for entries flagged verify.
//  Ports       : clk, reset_n             - clock, async active-low reset
//                init_start               - start pulse (IDLE/DONE/ERROR only)
//                controller_busy, missed_ack - sequencer status
//                codec_data_out(_valid)   - readback data
//                codec_wr_en/codec_rd_en  - one-cycle request pulses
//                codec_reg_addr/data_in   - held request address/data
//                init_busy/done/error, err_index - sequence status
//  Revision    : 1.0 - initial release
// ============================================================================
module codec_init_seq
    import codec_init_pkg::*;
#(
    parameter int          NUM_ENTRIES    = 10,
    parameter int          RETRY_MAX      = 3,
    parameter logic [15:0] ACTIVATE_DELAY = 16'd50000,
    parameter logic [15:0] BUSY_TIMEOUT   = 16'd1023
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init_start,
    input  logic       controller_busy,
    input  logic       missed_ack,
    input  logic [8:0] codec_data_out,
    input  logic       codec_data_out_valid,
    output logic       codec_wr_en,
    output logic       codec_rd_en,
    output logic [7:0] codec_reg_addr,
    output logic [8:0] codec_data_in,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_error,
    output logic [3:0] err_index
);

    localparam logic [3:0] S_IDLE     = ST_IDLE;
    localparam logic [3:0] S_ISSUE    = ST_ISSUE;
    localparam logic [3:0] S_WAIT_HI  = ST_WAIT_HI;
    localparam logic [3:0] S_WAIT_LO  = ST_WAIT_LO;
    localparam logic [3:0] S_CHECK    = ST_CHECK;
    localparam logic [3:0] S_DELAY    = ST_DELAY;
    localparam logic [3:0] S_RB_ISSUE = ST_RB_ISSUE;
    localparam logic [3:0] S_RB_WAIT  = ST_RB_WAIT;
    localparam logic [3:0] S_DONE     = ST_DONE;
    localparam logic [3:0] S_ERROR    = ST_ERROR;

    localparam logic [3:0] C_NUM       = 4'(NUM_ENTRIES);
    localparam logic [3:0] C_RETRY_MAX = 4'(RETRY_MAX);

    logic [3:0]   r_state;
    logic [3:0]   r_index;
    logic [3:0]   r_retry;
    logic         r_wr_en;
    logic [7:0]   r_addr;
    logic [8:0]   r_data;
    logic         r_busy;
    logic         r_done;
    logic         r_error;
    logic [3:0]   r_err_index;

    codec_entry_t w_cur;
    codec_entry_t w_next;
    codec_entry_t w_first;
    logic [3:0]   w_index_nxt;
    logic         w_start;
    logic         w_issue_fire;
    logic         w_timeout;
    logic         w_ack_ok;
    logic         w_go_rb;
    logic         w_attempt_fail;
    logic         w_attempt_ok;
    logic         w_tmr_load;
    logic [15:0]  w_tmr_value;
    logic         w_tmr_en;
    logic         w_tmr_expired;
    logic         w_unused;

    assign w_index_nxt  = r_index + 4'd1;
    assign w_cur        = default_entry(r_index);
    assign w_next       = default_entry(w_index_nxt);
    assign w_first      = default_entry(4'd0);

    assign w_start      = init_start &&
                          ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_issue_fire = (r_state == S_ISSUE) && !controller_busy;
    assign w_timeout    = (r_state == S_WAIT_HI) && !controller_busy && w_tmr_expired;
    assign w_ack_ok     = (r_state == S_CHECK) && !missed_ack;

`ifdef CODEC_INIT_READBACK_EN
    logic r_rd_en;
    logic w_rb_done;

    assign w_rb_done      = (r_state == S_RB_WAIT) && codec_data_out_valid;
    assign w_go_rb        = w_ack_ok && w_cur.verify;
    assign w_attempt_fail = w_timeout || ((r_state == S_CHECK) && missed_ack) ||
                            (w_rb_done && (codec_data_out != w_cur.data));
    assign w_attempt_ok   = (w_ack_ok && !w_cur.verify) ||
                            (w_rb_done && (codec_data_out == w_cur.data));
    assign codec_rd_en    = r_rd_en;
    assign w_unused       = ^{w_next.addr, w_next.data, w_next.verify, w_first.addr,
                              w_first.data, w_first.verify, w_cur.delay_before};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_en <= 1'b0;
        end else begin
            r_rd_en <= (r_state == S_RB_ISSUE) && !controller_busy;
        end
    end
`else
    assign w_go_rb        = 1'b0;
    assign w_attempt_fail = w_timeout || ((r_state == S_CHECK) && missed_ack);
    assign w_attempt_ok   = w_ack_ok;
    assign codec_rd_en    = 1'b0;
    assign w_unused       = ^{w_next.addr, w_next.data, w_next.verify, w_first.addr,
                              w_first.data, w_first.verify, w_cur.delay_before,
                              w_cur.verify, codec_data_out, codec_data_out_valid};
`endif

    // One counter serves both waits: it is armed for the busy timeout on every
    // issue and for the activate delay whenever a delay_before entry is next.
    // Loading N-1 makes the waiting state last exactly N cycles.
    assign w_tmr_load  = w_issue_fire ||
                         (w_start && w_first.delay_before) ||
                         (w_attempt_ok && (w_index_nxt != C_NUM) && w_next.delay_before);
    assign w_tmr_value = w_issue_fire ? (BUSY_TIMEOUT - 16'd1) : (ACTIVATE_DELAY - 16'd1);
    assign w_tmr_en    = (r_state == S_WAIT_HI) || (r_state == S_DELAY);

    codec_init_timer #(
        .WIDTH (16)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .i_enable     (w_tmr_en),
        .o_expired    (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_index     <= 4'd0;
            r_retry     <= 4'd0;
            r_wr_en     <= 1'b0;
            r_addr      <= 8'd0;
            r_data      <= 9'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= 4'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (init_start) begin
                        r_index     <= 4'd0;
                        r_retry     <= 4'd0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_index <= 4'd0;
                        r_busy      <= 1'b1;
                        r_state     <= w_first.delay_before ? S_DELAY : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!controller_busy) begin
                        r_wr_en <= 1'b1;
                        r_addr  <= {1'b0, w_cur.addr};
                        r_data  <= w_cur.data;
                        r_state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI:  if (controller_busy)  r_state <= S_WAIT_LO;
                S_WAIT_LO:  if (!controller_busy) r_state <= S_CHECK;
                S_CHECK:    r_state <= S_CHECK;
                S_DELAY:    if (w_tmr_expired)    r_state <= S_ISSUE;
                S_RB_ISSUE: if (!controller_busy) r_state <= S_RB_WAIT;
                S_RB_WAIT:  r_state <= S_RB_WAIT;
                default:    r_state <= S_IDLE;
            endcase

            // Attempt outcomes override the per-state moves above.
            if (w_go_rb) begin
                r_state <= S_RB_ISSUE;
            end
            if (w_attempt_fail) begin
                if (r_retry >= C_RETRY_MAX) begin
                    r_err_index <= r_index;
                    r_error     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_ERROR;
                end else begin
                    r_retry <= r_retry + 4'd1;
                    r_state <= S_ISSUE;
                end
            end
            if (w_attempt_ok) begin
                r_retry <= 4'd0;
                r_index <= w_index_nxt;
                if (w_index_nxt == C_NUM) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end else if (w_next.delay_before) begin
                    r_state <= S_DELAY;
                end else begin
                    r_state <= S_ISSUE;
                end
            end
        end
    end

    assign codec_wr_en    = r_wr_en;
    assign codec_reg_addr = r_addr;
    assign codec_data_in  = r_data;
    assign init_busy      = r_busy;
    assign init_done      = r_done;
    assign init_error     = r_error;
    assign err_index      = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_codec_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_codec_init_seq
//  Description : Self-checking bench for codec_init_seq. A behavioural I2C
//                sequencer drives busy/ack/readback with random latencies;
//                expected write streams are derived from the init table and
//                the retry rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_init_seq;

    localparam logic [15:0] ACT_DLY   = 16'd200;
    localparam int          RETRY_MAX = 3;

`ifdef CODEC_INIT_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    localparam logic [6:0] T_ADDR [0:9] = '{7'h0F, 7'h06, 7'h00, 7'h01, 7'h04,
                                            7'h05, 7'h07, 7'h08, 7'h09, 7'h06};
    localparam logic [8:0] T_DATA [0:9] = '{9'h000, 9'h010, 9'h017, 9'h017, 9'h012,
                                            9'h000, 9'h00A, 9'h000, 9'h001, 9'h000};
    localparam bit         T_VER  [0:9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       init_start = 1'b0;
    logic       controller_busy = 1'b0;
    logic       missed_ack = 1'b0;
    logic [8:0] codec_data_out = 9'd0;
    logic       codec_data_out_valid = 1'b0;
    logic       codec_wr_en, codec_rd_en;
    logic [7:0] codec_reg_addr;
    logic [8:0] codec_data_in;
    logic       init_busy, init_done, init_error;
    logic [3:0] err_index;

    codec_init_seq #(
        .NUM_ENTRIES    (10),
        .RETRY_MAX      (RETRY_MAX),
        .ACTIVATE_DELAY (ACT_DLY),
        .BUSY_TIMEOUT   (16'd1023)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .init_start           (init_start),
        .controller_busy      (controller_busy),
        .missed_ack           (missed_ack),
        .codec_data_out       (codec_data_out),
        .codec_data_out_valid (codec_data_out_valid),
        .codec_wr_en          (codec_wr_en),
        .codec_rd_en          (codec_rd_en),
        .codec_reg_addr       (codec_reg_addr),
        .codec_data_in        (codec_data_in),
        .init_busy            (init_busy),
        .init_done            (init_done),
        .init_error           (init_error),
        .err_index            (err_index)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- sequencer model state ----------------
    logic [16:0] wr_q [$];
    int          gap_q [$];
    logic [16:0] exp_q [$];
    logic [8:0]  mem [0:127];
    int  cyc = 0, last_fall = 0;
    int  phase = 0, rise_cnt = 0, fall_cnt = 0;
    int  rd_cnt = 0, viol = 0;
    int  cur_entry = 0, miss_entry = -1, miss_left = 0;
    bit  busy_enable = 1'b1, rb_fault = 1'b0, rd_pending = 1'b0;
    logic [6:0] rd_addr = 7'd0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            codec_data_out_valid = 1'b0;
            if (!reset_n) begin
                controller_busy = 1'b0;
                phase = 0;
                rd_pending = 1'b0;
            end else if (codec_wr_en || codec_rd_en) begin
                if (busy_enable && (controller_busy || phase != 0)) viol++;
                if (codec_wr_en) begin
                    wr_q.push_back({codec_reg_addr, codec_data_in});
                    gap_q.push_back(cyc - last_fall);
                    mem[codec_reg_addr[6:0]] = codec_data_in;
                    if (cur_entry == miss_entry && miss_left > 0) begin
                        missed_ack = 1'b1;
                        miss_left--;
                    end else begin
                        missed_ack = 1'b0;
                        if (!(RB_EN && cur_entry < 10 && T_VER[cur_entry])) cur_entry++;
                    end
                end
                if (codec_rd_en) begin
                    rd_cnt++;
                    rd_pending = 1'b1;
                    rd_addr = codec_reg_addr[6:0];
                end
                if (busy_enable) begin
                    phase    = 1;
                    rise_cnt = $urandom_range(1, 4);
                    fall_cnt = $urandom_range(5, 22);
                end
            end else if (phase == 1) begin
                rise_cnt--;
                if (rise_cnt == 0) begin
                    controller_busy = 1'b1;
                    phase = 2;
                end
            end else if (phase == 2) begin
                fall_cnt--;
                if (fall_cnt == 0) begin
                    controller_busy = 1'b0;
                    phase = 0;
                    last_fall = cyc;
                    if (rd_pending) begin
                        rd_pending = 1'b0;
                        codec_data_out = (rb_fault && rd_addr == 7'h00) ? 9'h016 : mem[rd_addr];
                        codec_data_out_valid = 1'b1;
                        if (codec_data_out == mem[rd_addr]) cur_entry++;
                    end
                end
            end
        end
    end

    // ---------------- bench helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
    endtask

    task automatic wait_end(input int max);
        int n = 0;
        while (!(init_done || init_error) && n < max) begin
            tick();
            n++;
        end
        check("end_reached", 32'(n < max), 32'd1);
    endtask

    // Expected write stream: every entry once, the missed entry (mn misses)
    // repeated; beyond RETRY_MAX misses the sequence stops after
    // RETRY_MAX+1 attempts on that entry.
    task automatic build_expected(input int me, input int mn, output bit exp_err);
        exp_err = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            int att;
            att = 1;
            if (i == me) att = (mn > RETRY_MAX) ? RETRY_MAX + 1 : mn + 1;
            for (int a = 0; a < att; a++) exp_q.push_back({1'b0, T_ADDR[i], T_DATA[i]});
            if (i == me && mn > RETRY_MAX) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_case(input int me, input int mn, input bit fault_rb);
        bit e;
        build_expected(me, mn, e);
        wr_q.delete();
        gap_q.delete();
        rd_cnt     = 0;
        viol       = 0;
        cur_entry  = 0;
        rb_fault   = fault_rb;
        miss_entry = fault_rb ? -1 : me;
        miss_left  = fault_rb ? 0 : mn;
        pulse_start();
        check("busy_after_start", 32'(init_busy), 32'd1);
        wait_end(20000);
        repeat (100) tick();
        check("pulse_count", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            check($sformatf("pulse%0d_addr_data", i), 32'(wr_q[i]), 32'(exp_q[i]));
        check("init_done",  32'(init_done),  32'(!e));
        check("init_error", 32'(init_error), 32'(e));
        check("init_busy_end", 32'(init_busy), 32'd0);
        if (e) check("err_index", 32'(err_index), 32'(me));
        check("req_overlap", 32'(viol), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"},   32'(codec_wr_en),    32'd0);
        check({tag, "_rd_en"},   32'(codec_rd_en),    32'd0);
        check({tag, "_addr"},    32'(codec_reg_addr), 32'd0);
        check({tag, "_data"},    32'(codec_data_in),  32'd0);
        check({tag, "_busy"},    32'(init_busy),      32'd0);
        check({tag, "_done"},    32'(init_done),      32'd0);
        check({tag, "_error"},   32'(init_error),     32'd0);
        check({tag, "_errindex"}, 32'(err_index),     32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < 128; i++) mem[i] = 9'd0;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick();
        check("no_pulse_after_release", 32'(codec_wr_en), 32'd0);

        // Clean run, including the activate delay ahead of R9.
        run_case(-1, 0, 1'b0);
        if (gap_q.size() > 8)
            check("r9_delay_gap_ok", 32'(gap_q[8] >= int'(ACT_DLY)), 32'd1);
        check("readback_count", 32'(rd_cnt), RB_EN ? 32'd6 : 32'd0);

        // Two missed ACKs on entry 3, then success.
        run_case(3, 2, 1'b0);
        // Permanent missed ACK on entry 2.
        run_case(2, 1000, 1'b0);
        // Busy never rises: four timed-out attempts on entry 0.
        busy_enable = 1'b0;
        run_case(0, 1000, 1'b0);
        busy_enable = 1'b1;

        // Reset while waiting for busy to fall on entry 5.
        wr_q.delete();
        cur_entry  = 0;
        miss_entry = -1;
        miss_left  = 0;
        viol       = 0;
        pulse_start();
        n = 0;
        while (!(wr_q.size() == 6 && controller_busy) && n < 5000) begin
            tick();
            n++;
        end
        check("reach_entry5", 32'(n < 5000), 32'd1);
        tick();
        tick();
        check("busy_before_reset", 32'(init_busy), 32'd1);
        check("addr_before_reset", 32'(codec_reg_addr), 32'h05);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("no_pulse_after_midrst", 32'(codec_wr_en), 32'd0);
        run_case(-1, 0, 1'b0);

        // Randomized ACK faults.
        for (int k = 0; k < 3; k++) begin
            int me, mn;
            me = $urandom_range(0, 9);
            mn = $urandom_range(0, 5);
            run_case(me, mn, 1'b0);
        end

`ifdef CODEC_INIT_READBACK_EN
        // R0 reads back wrong every time: four write+read pairs, then error.
        run_case(2, 1000, 1'b1);
        check("rb_fault_reads", 32'(rd_cnt), 32'd4);
        rb_fault = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/codec_init_seq.md
CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameter NUM_ENTRIES, default 10, number of init-table entries executed.
REQ-002 Parameter RETRY_MAX, default 3, retries per entry after a missed ACK or timeout.
REQ-003 Parameter ACTIVATE_DELAY, default 16'd50000, idle clk cycles inserted before any entry flagged delay_before.
REQ-004 Parameter BUSY_TIMEOUT, default 16'd1023, max cycles between a request pulse and controller_busy rising.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 init_start  in  1  one-cycle pulse that starts the sequence; ignored unless in IDLE, DONE or ERROR.
REQ-008 controller_busy  in  1  busy from the downstream I2C sequencer.
REQ-009 missed_ack  in  1  level from the I2C sequencer, valid once controller_busy has fallen.
REQ-010 codec_data_out / codec_data_out_valid  in  9 / 1  readback data and strobe.
REQ-011 codec_wr_en / codec_rd_en  out  1 / 1  one-cycle request pulses.
REQ-012 codec_reg_addr  out  8  {1'b0, entry addr[6:0]}.
REQ-013 codec_data_in  out  9  entry data.
REQ-014 init_busy / init_done / init_error  out  1 each  sequence status.
REQ-015 err_index  out  4  index of the entry that failed.

Function
REQ-016 States: IDLE, ISSUE, WAIT_HI, WAIT_LO, CHECK, DELAY, RB_ISSUE, RB_WAIT, DONE, ERROR.
REQ-017 On init_start: clear index, retry count, done, error and err_index; set init_busy; go to ISSUE.
  - If entry[0] has delay_before set, go to DELAY instead.
REQ-018 ISSUE: only when controller_busy==0, drive addr/data and pulse codec_wr_en for exactly one cycle; go to WAIT_HI.
  - Addr/data are held stable until the next issue.
REQ-019 WAIT_HI: when controller_busy==1, go to WAIT_LO.
  - If BUSY_TIMEOUT cycles elapse first, treat the attempt as failed (REQ-021).
REQ-020 WAIT_LO: when controller_busy==0, go to CHECK. No timeout applies here.
REQ-021 CHECK: sample missed_ack.
  - missed_ack==1: increment retry count and return to ISSUE.
  - Once retries exceed RETRY_MAX, load err_index with the index, set init_error, go to ERROR.
REQ-022 CHECK, ack OK: clear retry count and increment index.
  - Index==NUM_ENTRIES: go to DONE.
  - Else if the next entry has delay_before set: go to DELAY.
  - Else: go to ISSUE.
REQ-023 DELAY: count ACTIVATE_DELAY cycles, then go to ISSUE.
REQ-024 DONE: init_busy=0 and init_done=1, both held until the next init_start.
REQ-025 ERROR: init_busy=0 and init_error=1, both held until the next init_start.
REQ-026 No request pulse is ever issued while controller_busy==1; never more than one outstanding request.
REQ-027 init_start while busy is ignored; an init_start in the same cycle as a DONE transition is ignored.

Reset
REQ-028 On reset_n low, asynchronously clear every output to 0 and return the FSM to IDLE.
  - Index, retry count, timeout counter and delay counter clear to 0.
  - A sequence in progress is abandoned; no request pulse is issued on the first cycle after release.

Configuration
REQ-029 Macro CODEC_INIT_READBACK_EN enables readback verification.
REQ-030 With CODEC_INIT_READBACK_EN defined: after an ack-OK CHECK on an entry with verify set, go to RB_ISSUE.
  - RB_ISSUE pulses codec_rd_en once controller_busy==0.
  - RB_WAIT waits for codec_data_out_valid.
  - Mismatch vs entry data counts as a failed attempt (REQ-021); a match continues per REQ-022.
REQ-031 Without CODEC_INIT_READBACK_EN: RB states are absent, codec_rd_en is tied 0, and the verify flags are ignored.

Structure
REQ-032 Package codec_init_pkg holds:
  - entry typedef {addr[6:0], data[8:0], delay_before, verify};
  - state enum;
  - the default SSM2603 table: R15=0x000; R6=0x010; R0=0x017; R1=0x017; R4=0x012; R5=0x000; R7=0x00A; R8=0x000; R9=0x001 (delay_before); R6=0x000.
REQ-033 One sub-module, codec_init_timer, provides the shared timeout/delay down-counter with load, enable and expire signals.

Verification
REQ-034 Clean run: busy model high 2 cycles after each pulse for 20 cycles, missed_ack=0.
  - Exactly 10 codec_wr_en pulses, addr/data matching the table in order.
  - ≥ACTIVATE_DELAY idle cycles before the R9 pulse; init_done=1.
REQ-035 missed_ack=1 on entry 3 for 2 attempts: entry 3 is issued 3 times; sequence completes; init_error=0.
REQ-036 missed_ack=1 permanently on entry 2: 4 pulses for entry 2; init_error=1; err_index=2; no further pulses.
REQ-037 Busy never rises: timeout after 1023 cycles; 4 attempts total; then ERROR with err_index=0.
REQ-038 Assert reset_n mid-WAIT_LO on entry 5: all outputs 0 immediately. New init_start restarts from entry 0.
REQ-039 With READBACK_EN, readback returns 0x016 for R0: 4 write+read pairs for R0; init_error=1; err_index=2.
